core_intc: RTL and testbench

CORE_INTC -- requirements
Module: core_intc

---
 rtl/core_intc_pkg.sv | 20 ++
 rtl/core_intc_edge.sv | 61 ++++++
 rtl/core_intc.sv | 129 ++++++++++++
 tb/tb_core_intc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_intc_pkg.sv
// Shared types and constants for the core interrupt controller.
// Holds the grant-kind encoding reported on O_kind and the default
// vector addresses used by core_intc's parameter defaults.
package core_intc_pkg;

  // Source type of the most recent grant.
  typedef enum logic [1:0] {
    kind_reset = 2'd0,
    kind_chan  = 2'd1,
    kind_brk   = 2'd2
  } kind_e;

  localparam logic [15:0] DEFAULT_RESET_VEC = 16'hFFFC;
  localparam logic [15:0] DEFAULT_BRK_VEC   = 16'hFFFE;
  localparam logic [15:0] DEFAULT_NMI_VEC   = 16'hFFFA;
  localparam logic [15:0] DEFAULT_IRQ_VEC   = 16'hFFFE;

  localparam int CHAN_IDX_W = 3;

endpackage

// File: rtl/core_intc_edge.sv
// One interrupt request channel: two-flop synchroniser for the async
// active-low request line, followed by either a falling-edge latch or a
// plain level follower.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   src_n   - raw active-low request line (asynchronous)
//   clr     - grant of this channel; clears the edge latch
//   pending - channel has a request outstanding
module core_intc_edge #(
  parameter bit IS_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_n,
  input  logic clr,
  output logic pending
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic latch_q, latch_d;
  logic fall;

  // prev_q holds last clock's synchronised value, so the edge is judged
  // purely on the second synchroniser flop. A fresh edge outranks a clear
  // so an edge arriving on the grant clock is not lost.
  always_comb begin
    sync1_d = src_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fall    = prev_q & ~sync2_q;
    latch_d = latch_q;
    if (clr) begin
      latch_d = 1'b0;
    end
    if (fall) begin
      latch_d = 1'b1;
    end
  end

  // Synchroniser idles high (no request) so reset release never looks
  // like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      latch_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      latch_q <= latch_d;
    end
  end

  assign pending = IS_EDGE ? latch_q : ~sync2_q;

endmodule

// File: rtl/core_intc.sv
// Core interrupt controller: collects CHANNELS active-low request lines,
// masks them by per-channel enable and the CPU interrupt-disable flag
// (NMI channels bypass the flag), and on each CPU instruction boundary
// registers the highest-priority source as a vector/channel/kind grant.
// A pending reset outranks every channel; with nothing eligible the grant
// falls back to the soft BRK vector.
// Ports:
//   I_clock   - system clock
//   I_reset   - asynchronous active-low reset
//   I_src     - active-low request lines, one per channel
//   I_enable  - per-channel arbitration enable
//   I_iflag   - CPU interrupt-disable flag
//   I_strobe  - one-clock CPU cycle qualifier
//   I_ack     - CPU at instruction boundary
//   O_pending - an eligible request exists
//   O_vector  - granted vector address
//   O_channel - granted channel index (0 for reset/BRK)
//   O_kind    - granted source type
module core_intc
  import core_intc_pkg::*;
#(
  parameter int                       CHANNELS  = 2,
  parameter logic [CHANNELS-1:0]      EDGE_MASK = 2'b01,
  parameter logic [CHANNELS-1:0]      NMI_MASK  = 2'b01,
  parameter logic [CHANNELS*16-1:0]   VECTORS   = {DEFAULT_IRQ_VEC, DEFAULT_NMI_VEC},
  parameter logic [15:0]              RESET_VEC = DEFAULT_RESET_VEC,
  parameter logic [15:0]              BRK_VEC   = DEFAULT_BRK_VEC
) (
  input  logic                  I_clock,
  input  logic                  I_reset,
  input  logic [CHANNELS-1:0]   I_src,
  input  logic [CHANNELS-1:0]   I_enable,
  input  logic                  I_iflag,
  input  logic                  I_strobe,
  input  logic                  I_ack,
  output logic                  O_pending,
  output logic [15:0]           O_vector,
  output logic [CHAN_IDX_W-1:0] O_channel,
  output logic [1:0]            O_kind
);

  logic                  reset_pending_q, reset_pending_d;
  logic [15:0]           vector_q, vector_d;
  logic [CHAN_IDX_W-1:0] channel_q, channel_d;
  kind_e                 kind_q, kind_d;

  logic [CHANNELS-1:0]   chan_pending;
  logic [CHANNELS-1:0]   eligible;
  logic [CHANNELS-1:0]   clr;
  logic                  grant;
  logic                  found;
  int                    win_idx;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    core_intc_edge #(
      .IS_EDGE (EDGE_MASK[gi])
    ) u_edge (
      .clk     (I_clock),
      .rst_n   (I_reset),
      .src_n   (I_src[gi]),
      .clr     (clr[gi]),
      .pending (chan_pending[gi])
    );
  end

  assign eligible  = chan_pending & I_enable & (NMI_MASK | {CHANNELS{~I_iflag}});
  assign O_pending = reset_pending_q | (|eligible);
  assign grant     = I_ack & I_strobe;

  // Lowest-index eligible channel wins among the channels.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (eligible[i] && !found) begin
        found   = 1'b1;
        win_idx = i;
      end
    end
  end

  // Grant register: only a qualified ack (ack with strobe) moves the
  // outputs or consumes a request. Only the granted channel's latch is
  // cleared, and never while the reset grant is being taken.
  always_comb begin
    reset_pending_d = reset_pending_q;
    vector_d        = vector_q;
    channel_d       = channel_q;
    kind_d          = kind_q;
    for (int i = 0; i < CHANNELS; i++) begin
      clr[i] = grant && !reset_pending_q && found && (win_idx == i);
    end
    if (grant) begin
      if (reset_pending_q) begin
        reset_pending_d = 1'b0;
        vector_d        = RESET_VEC;
        channel_d       = '0;
        kind_d          = kind_reset;
      end else if (found) begin
        vector_d  = VECTORS[win_idx*16 +: 16];
        channel_d = CHAN_IDX_W'(win_idx);
        kind_d    = kind_chan;
      end else begin
        vector_d  = BRK_VEC;
        channel_d = '0;
        kind_d    = kind_brk;
      end
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      reset_pending_q <= 1'b1;
      vector_q        <= RESET_VEC;
      channel_q       <= '0;
      kind_q          <= kind_reset;
    end else begin
      reset_pending_q <= reset_pending_d;
      vector_q        <= vector_d;
      channel_q       <= channel_d;
      kind_q          <= kind_d;
    end
  end

  assign O_vector  = vector_q;
  assign O_channel = channel_q;
  assign O_kind    = kind_q;

endmodule

// File: tb/tb_core_intc.sv
// Self-checking bench for core_intc with default parameters:
// channel 0 is a falling-edge NMI at FFFA, channel 1 a maskable low-level
// request at FFFE. A behavioural model predicts the outputs every cycle;
// directed scenarios add hand-computed literal expectations.
module tb_core_intc;
  import core_intc_pkg::*;

  localparam int CH = 2;
  localparam logic [1:0] M_EDGE = 2'b01;
  localparam logic [1:0] M_NMI  = 2'b01;

  logic        I_clock;
  logic        I_reset;
  logic [1:0]  I_src;
  logic [1:0]  I_enable;
  logic        I_iflag;
  logic        I_strobe;
  logic        I_ack;
  logic        O_pending;
  logic [15:0] O_vector;
  logic [2:0]  O_channel;
  logic [1:0]  O_kind;

  int tests_run;
  int tests_failed;
  bit chk_en;

  core_intc #(
    .CHANNELS  (2),
    .EDGE_MASK (2'b01),
    .NMI_MASK  (2'b01),
    .VECTORS   ({16'hFFFE, 16'hFFFA}),
    .RESET_VEC (16'hFFFC),
    .BRK_VEC   (16'hFFFE)
  ) dut (
    .I_clock   (I_clock),
    .I_reset   (I_reset),
    .I_src     (I_src),
    .I_enable  (I_enable),
    .I_iflag   (I_iflag),
    .I_strobe  (I_strobe),
    .I_ack     (I_ack),
    .O_pending (O_pending),
    .O_vector  (O_vector),
    .O_channel (O_channel),
    .O_kind    (O_kind)
  );

  initial begin
    I_clock = 1'b0;
    forever #5 I_clock = ~I_clock;
  end

  // Behavioural model. samp[i] holds the last three raw samples of the
  // request line (bit0 newest); the synchronised value is the sample taken
  // two clocks ago, and an edge is that value dropping from 1 to 0.
  logic [15:0] m_vec_tab [CH];
  logic [2:0]  samp [CH];
  bit          m_latch [CH];
  bit          m_fall [CH];
  bit          m_rp;
  logic [15:0] m_vec;
  logic [2:0]  m_chan;
  logic [1:0]  m_kind;
  int          m_w;

  function automatic bit m_chan_pending(int i);
    if (M_EDGE[i]) return m_latch[i];
    return !samp[i][1];
  endfunction

  // -2 reset, -1 nothing eligible, else winning channel
  function automatic int m_winner();
    if (m_rp) return -2;
    for (int i = 0; i < CH; i++) begin
      if (m_chan_pending(i) && I_enable[i] && (M_NMI[i] || !I_iflag)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      samp[i]    = 3'b111;
      m_latch[i] = 1'b0;
    end
    m_rp   = 1'b1;
    m_vec  = 16'hFFFC;
    m_chan = 3'd0;
    m_kind = kind_reset;
  endtask

  initial begin
    m_vec_tab[0] = 16'hFFFA;
    m_vec_tab[1] = 16'hFFFE;
  end

  always @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      model_reset();
    end else begin
      m_w = m_winner();
      for (int i = 0; i < CH; i++) m_fall[i] = samp[i][2] && !samp[i][1];
      if (I_ack && I_strobe) begin
        if (m_w == -2) begin
          m_rp   = 1'b0;
          m_vec  = 16'hFFFC;
          m_chan = 3'd0;
          m_kind = kind_reset;
        end else if (m_w >= 0) begin
          m_vec      = m_vec_tab[m_w];
          m_chan     = 3'(m_w);
          m_kind     = kind_chan;
          m_latch[m_w] = 1'b0;
        end else begin
          m_vec  = 16'hFFFE;
          m_chan = 3'd0;
          m_kind = kind_brk;
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (m_fall[i]) m_latch[i] = 1'b1;
        samp[i] = {samp[i][1:0], I_src[i]};
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge I_clock) begin
    if (chk_en) begin
      tests_run++;
      if (O_pending !== (m_winner() != -1) || O_vector !== m_vec ||
          O_channel !== m_chan || O_kind !== m_kind) begin
        tests_failed++;
        $display("[TB] FAIL model_compare t=%0t: got pend=%b vec=%h ch=%0d kind=%0d, want pend=%b vec=%h ch=%0d kind=%0d",
                 $time, O_pending, O_vector, O_channel, O_kind,
                 (m_winner() != -1), m_vec, m_chan, m_kind);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] src, input logic [1:0] en,
                               input logic iflag, input logic strobe, input logic ack);
    @(negedge I_clock);
    #1;
    I_src    = src;
    I_enable = en;
    I_iflag  = iflag;
    I_strobe = strobe;
    I_ack    = ack;
  endtask

  task automatic doGrant(input logic [1:0] src, input logic [1:0] en, input logic iflag);
    applyStimulus(src, en, iflag, 1'b1, 1'b1);
    applyStimulus(src, en, iflag, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic exp_pend, input logic [15:0] exp_vec,
                             input logic [2:0] exp_ch, input logic [1:0] exp_kind);
    @(negedge I_clock);
    tests_run++;
    if (O_pending !== exp_pend || O_vector !== exp_vec || O_channel !== exp_ch || O_kind !== exp_kind) begin
      tests_failed++;
      $display("[TB] FAIL %s: got pend=%b vec=%h ch=%0d kind=%0d, want pend=%b vec=%h ch=%0d kind=%0d",
               name, O_pending, O_vector, O_channel, O_kind, exp_pend, exp_vec, exp_ch, exp_kind);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    tests_run    = 0;
    tests_failed = 0;
    chk_en       = 1'b0;
    I_reset  = 1'b1;
    I_src    = 2'b11;
    I_enable = 2'b11;
    I_iflag  = 1'b1;
    I_strobe = 1'b0;
    I_ack    = 1'b0;
    #1 I_reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge I_clock);
    #1 I_reset = 1'b1;
    checkOutput("reset_state", 1'b1, 16'hFFFC, 3'd0, kind_reset);

    // Reset grant, then BRK with nothing eligible
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("reset_grant", 1'b0, 16'hFFFC, 3'd0, kind_reset);
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("brk_grant", 1'b0, 16'hFFFE, 3'd0, kind_brk);

    // One-clock NMI pulse with interrupts disabled
    applyStimulus(2'b10, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 3 && !got; k++) begin
      @(negedge I_clock);
      got = O_pending;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL nmi_pending_latency: got pend=0 after 3 clocks, want pend=1");
    end

    // Unqualified ack/strobe change nothing
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b1);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    checkOutput("unqualified_ack", 1'b1, 16'hFFFE, 3'd0, kind_brk);

    // Disabled channel keeps its latch but is not granted
    applyStimulus(2'b11, 2'b10, 1'b1, 1'b0, 1'b0);
    checkOutput("ch0_disabled", 1'b0, 16'hFFFE, 3'd0, kind_brk);
    doGrant(2'b11, 2'b10, 1'b1);
    checkOutput("disabled_grant_brk", 1'b0, 16'hFFFE, 3'd0, kind_brk);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    checkOutput("ch0_reenabled", 1'b1, 16'hFFFE, 3'd0, kind_brk);
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("ch0_grant", 1'b0, 16'hFFFA, 3'd0, kind_chan);

    // Level channel masked by iflag, then granted twice without clearing
    applyStimulus(2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
    checkOutput("level_masked", 1'b0, 16'hFFFA, 3'd0, kind_chan);
    applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    checkOutput("level_unmasked", 1'b1, 16'hFFFA, 3'd0, kind_chan);
    doGrant(2'b01, 2'b11, 1'b0);
    checkOutput("level_grant1", 1'b1, 16'hFFFE, 3'd1, kind_chan);
    doGrant(2'b01, 2'b11, 1'b0);
    checkOutput("level_grant2", 1'b1, 16'hFFFE, 3'd1, kind_chan);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    checkOutput("level_released", 1'b0, 16'hFFFE, 3'd1, kind_chan);

    // Simultaneous edge on ch0 and level on ch1: priority order
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    doGrant(2'b01, 2'b11, 1'b0);
    checkOutput("multi_grant_ch0", 1'b1, 16'hFFFA, 3'd0, kind_chan);
    doGrant(2'b01, 2'b11, 1'b0);
    checkOutput("multi_grant_ch1", 1'b1, 16'hFFFE, 3'd1, kind_chan);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    checkOutput("multi_released", 1'b0, 16'hFFFE, 3'd1, kind_chan);

    // Second ch0 edge detected on the very clock ch0 is granted
    applyStimulus(2'b10, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("set_wins_grant", 1'b1, 16'hFFFA, 3'd0, kind_chan);
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("set_wins_regrant", 1'b0, 16'hFFFA, 3'd0, kind_chan);

    // Reset mid-stream discards a latched edge
    applyStimulus(2'b10, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_latched", 1'b1, 16'hFFFA, 3'd0, kind_chan);
    #1 I_reset = 1'b0;
    @(negedge I_clock);
    checkOutput("in_reset", 1'b1, 16'hFFFC, 3'd0, kind_reset);
    #1 I_reset = 1'b1;
    checkOutput("post_reset", 1'b1, 16'hFFFC, 3'd0, kind_reset);
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("post_reset_grant", 1'b0, 16'hFFFC, 3'd0, kind_reset);
    doGrant(2'b11, 2'b11, 1'b1);
    checkOutput("post_reset_brk", 1'b0, 16'hFFFE, 3'd0, kind_brk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
